router_pkt_rx: RTL and testbench

- Downstream consumer for one output port of the 1x3 router (router_top).
- Drains the port's FIFO by driving read_enb, then rebuilds each packet: header {len[5:0], addr[1:0]}, len payload bytes, then parity (the XOR of the header and all payload bytes).
- Checks the destination address and the parity, streams the payload out, and keeps packet and error counters.
- Used as the self-checking sink in the system bench and as the reference consumer in the FPGA demo.

---
 rtl/router_pkt_rx_if.sv | 34 +++
 rtl/router_pkt_rx.sv | 152 +++++++++++++++
 tb/tb_router_pkt_rx.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_rx_if.sv
// Router port to packet receiver bus.
// Groups the FIFO drain handshake (vld_out, data_out, read_enb), the sink
// backpressure (hold) and the packet status / payload outputs of router_pkt_rx.
//   master : the router port / system side (drives FIFO data and hold)
//   slave  : the packet receiver (drives read strobe, payload and status)
interface router_pkt_rx_if #(
  parameter int CNT_W = 16
);
  logic             vld_out;
  logic [7:0]       data_out;
  logic             hold;
  logic             read_enb;
  logic [7:0]       byte_out;
  logic             byte_valid;
  logic             pkt_done;
  logic [5:0]       pkt_len;
  logic             parity_err;
  logic             addr_err;
  logic             trunc_err;
  logic [CNT_W-1:0] pkt_count;
  logic [CNT_W-1:0] err_count;

  modport master (
    output vld_out, data_out, hold,
    input  read_enb, byte_out, byte_valid, pkt_done, pkt_len,
           parity_err, addr_err, trunc_err, pkt_count, err_count
  );

  modport slave (
    input  vld_out, data_out, hold,
    output read_enb, byte_out, byte_valid, pkt_done, pkt_len,
           parity_err, addr_err, trunc_err, pkt_count, err_count
  );
endinterface

// File: rtl/router_pkt_rx.sv
// Packet receiver for one output port of the 1x3 router.
// Drains the port FIFO with read_enb, rebuilds each packet
// (header {len, addr}, len payload bytes, parity byte), checks address and
// parity, streams the payload and keeps saturating good/error packet counters.
// Ports:
//   clock  : system clock, all logic on posedge
//   reset  : synchronous, active-high
//   bus    : router_pkt_rx_if.slave
//            in  vld_out, data_out[7:0], hold
//            out read_enb (combinational), byte_out, byte_valid, pkt_done,
//                pkt_len, parity_err, addr_err, trunc_err, pkt_count, err_count
module router_pkt_rx #(
  parameter logic [1:0] PORT_ID = 2'd0,
  parameter int         RD_LAT  = 1,
  parameter int         TIMEOUT = 64,
  parameter int         CNT_W   = 16
) (
  input logic            clock,
  input logic            reset,
  router_pkt_rx_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HDR_RD, HDR_WAIT, BODY, DONE} state_t;

  state_t            state;
  logic [6:0]        reads_left;
  logic [RD_LAT-1:0] strobe;
  logic [5:0]        len;
  logic [1:0]        addr;
  logic [7:0]        calc;
  logic [7:0]        parity;
  logic [6:0]        rx_idx;
  logic [TW-1:0]     tmo;
  logic              capture;
  logic              active;
  logic              timed_out;
  logic              parity_bad;
  logic              addr_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // A read's data is valid when its strobe falls out of the latency pipe.
  assign capture = strobe[RD_LAT-1];
  assign active  = (state == HDR_WAIT) || (state == BODY);

  // reads_left bounds reads to exactly len+2 per packet, so the next packet
  // waiting in the FIFO is never touched early.
  assign bus.read_enb = bus.vld_out & ~bus.hold & (reads_left != 7'd0) &
                        ((state == HDR_RD) || (state == BODY));

  // Abort fires on the cycle that would bring the idle counter to TIMEOUT.
  assign timed_out  = active && !capture && !bus.hold && (tmo == TW'(TIMEOUT - 1));
  assign parity_bad = (calc != parity);
  assign addr_bad   = (addr == 2'b11) || (addr != PORT_ID);

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      reads_left     <= '0;
      strobe         <= '0;
      len            <= '0;
      addr           <= '0;
      calc           <= '0;
      parity         <= '0;
      rx_idx         <= '0;
      tmo            <= '0;
      bus.byte_out   <= '0;
      bus.byte_valid <= 1'b0;
      bus.pkt_done   <= 1'b0;
      bus.pkt_len    <= '0;
      bus.parity_err <= 1'b0;
      bus.addr_err   <= 1'b0;
      bus.trunc_err  <= 1'b0;
      bus.pkt_count  <= '0;
      bus.err_count  <= '0;
    end else begin
      bus.byte_valid <= 1'b0;
      bus.pkt_done   <= 1'b0;
      strobe         <= (strobe << 1) | RD_LAT'(bus.read_enb);
      if (bus.read_enb) reads_left <= reads_left - 7'd1;

      // Idle-cycle counter: cleared by data, frozen while the sink holds.
      if (!active || capture) tmo <= '0;
      else if (!bus.hold)     tmo <= tmo + 1'b1;

      case (state)
        IDLE: begin
          if (bus.vld_out) begin
            reads_left <= 7'd1;
            state      <= HDR_RD;
          end
        end
        HDR_RD: begin
          if (bus.read_enb) state <= HDR_WAIT;
        end
        HDR_WAIT: begin
          if (capture) begin
            len        <= bus.data_out[7:2];
            addr       <= bus.data_out[1:0];
            calc       <= bus.data_out;
            reads_left <= {1'b0, bus.data_out[7:2]} + 7'd1;
            rx_idx     <= '0;
            state      <= BODY;
          end
        end
        BODY: begin
          if (capture) begin
            rx_idx <= rx_idx + 7'd1;
            if (rx_idx < {1'b0, len}) begin
              calc           <= calc ^ bus.data_out;
              bus.byte_out   <= bus.data_out;
              bus.byte_valid <= 1'b1;
            end else begin
              parity <= bus.data_out;
              state  <= DONE;
            end
          end
        end
        DONE: begin
          bus.pkt_done   <= 1'b1;
          bus.pkt_len    <= len;
          bus.parity_err <= parity_bad;
          bus.addr_err   <= addr_bad;
          bus.trunc_err  <= 1'b0;
          if (!parity_bad && !addr_bad) bus.pkt_count <= sat_inc(bus.pkt_count);
          else                          bus.err_count <= sat_inc(bus.err_count);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Timeout overrides everything above: drop in-flight reads and report.
      if (timed_out) begin
        bus.pkt_done   <= 1'b1;
        bus.pkt_len    <= len;
        bus.parity_err <= 1'b0;
        bus.addr_err   <= 1'b0;
        bus.trunc_err  <= 1'b1;
        bus.err_count  <= sat_inc(bus.err_count);
        strobe         <= '0;
        reads_left     <= '0;
        tmo            <= '0;
        state          <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_rx.sv
// Testbench for router_pkt_rx: two receivers (read latency 1 and 3) share one
// FIFO model; sel picks which receiver the FIFO currently feeds. Packets are
// built from random payloads and checked against a packet-level model.
module tb_router_pkt_rx;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int NVEC    = 8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  router_pkt_rx_if #(.CNT_W(CNT_W)) bus0 ();
  router_pkt_rx_if #(.CNT_W(CNT_W)) bus1 ();

  logic       sel;
  logic       src_vld;
  logic       hold;
  logic [7:0] pipe [3];

  assign bus0.vld_out  = src_vld & ~sel;
  assign bus1.vld_out  = src_vld & sel;
  assign bus0.hold     = hold;
  assign bus1.hold     = hold;
  assign bus0.data_out = pipe[0];
  assign bus1.data_out = pipe[2];

  router_pkt_rx #(.PORT_ID(2'd1), .RD_LAT(1), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut_lat1 (
    .clock(clock), .reset(reset), .bus(bus0));
  router_pkt_rx #(.PORT_ID(2'd1), .RD_LAT(3), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut_lat3 (
    .clock(clock), .reset(reset), .bus(bus1));

  logic             m_rd, m_bv, m_pd, m_perr, m_aerr, m_terr;
  logic [7:0]       m_byte;
  logic [5:0]       m_len;
  logic [CNT_W-1:0] m_pcnt, m_ecnt;

  always_comb begin
    if (sel) begin
      m_rd = bus1.read_enb;  m_bv = bus1.byte_valid; m_pd = bus1.pkt_done;
      m_perr = bus1.parity_err; m_aerr = bus1.addr_err; m_terr = bus1.trunc_err;
      m_byte = bus1.byte_out; m_len = bus1.pkt_len;
      m_pcnt = bus1.pkt_count; m_ecnt = bus1.err_count;
    end else begin
      m_rd = bus0.read_enb;  m_bv = bus0.byte_valid; m_pd = bus0.pkt_done;
      m_perr = bus0.parity_err; m_aerr = bus0.addr_err; m_terr = bus0.trunc_err;
      m_byte = bus0.byte_out; m_len = bus0.pkt_len;
      m_pcnt = bus0.pkt_count; m_ecnt = bus0.err_count;
    end
  end

  typedef struct {
    bit         sel;
    int         len;
    logic [1:0] addr;
    bit         bad;
    int         hold_mode;
    bit         b2b;
    bit         exp_perr;
    bit         exp_aerr;
  } vec_t;

  vec_t       vecs [NVEC];
  logic [7:0] src_q[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] got_q[$];
  int         errors, checks;
  int         rd_cnt, done_cnt, cyc, last_bv_cyc, done_cyc;
  bit         rd_pending;
  int         hold_mode, hold_left, next_hold_at, hold_limit;
  int         exp_pkt [2];
  int         exp_err [2];
  logic [5:0] s_len;
  logic       s_perr, s_aerr, s_terr;
  logic [CNT_W-1:0] s_pcnt, s_ecnt;

  task automatic check_output(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // One clock: FIFO model and hold update just after the edge, then
  // sample the selected receiver on the falling edge.
  task automatic step();
    @(posedge clock);
    #1;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    if (rd_pending && src_q.size() > 0) pipe[0] = src_q.pop_front();
    else                                pipe[0] = 8'($urandom);
    src_vld = (src_q.size() != 0);
    case (hold_mode)
      0: hold = 1'b0;
      1: begin
        if (hold_left > 0) begin
          hold = 1'b1;
          hold_left--;
        end else if (got_q.size() >= next_hold_at && got_q.size() < hold_limit) begin
          hold = 1'b1;
          hold_left = 4;
          next_hold_at += 4;
        end else begin
          hold = 1'b0;
        end
      end
      default: hold = ($urandom_range(0, 3) == 0);
    endcase
    @(negedge clock);
    cyc++;
    rd_pending = m_rd;
    if (m_rd) rd_cnt++;
    if (m_bv) begin
      got_q.push_back(m_byte);
      last_bv_cyc = cyc;
    end
    if (m_pd) begin
      done_cnt++;
      done_cyc = cyc;
      s_len = m_len; s_perr = m_perr; s_aerr = m_aerr; s_terr = m_terr;
      s_pcnt = m_pcnt; s_ecnt = m_ecnt;
    end
  endtask

  // Queue a packet in the FIFO; keep < len truncates it (no parity byte).
  task automatic apply_stimulus(input int len, input logic [1:0] addr, input bit bad, input int keep);
    logic [7:0] hdr, par;
    logic [7:0] pl[$];
    hdr = {6'(len), addr};
    par = hdr;
    for (int i = 0; i < len; i++) begin
      pl.push_back(8'($urandom));
      par ^= pl[i];
    end
    if (bad && len > 0 && par == hdr) begin
      pl[0] ^= 8'd1;
      par ^= 8'd1;
    end
    src_q.push_back(hdr);
    for (int i = 0; i < len && i < keep; i++) begin
      src_q.push_back(pl[i]);
      exp_bytes.push_back(pl[i]);
    end
    if (keep >= len) src_q.push_back(bad ? hdr : par);
  endtask

  task automatic expect_packet(input string tag, input int len, input bit perr, input bit aerr);
    int start, n, bad_bytes;
    logic [7:0] e;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 3000) begin
      step();
      n++;
    end
    check_output({tag, ".pkt_done"}, done_cnt - start, 1);
    check_output({tag, ".pkt_len"}, s_len, len);
    check_output({tag, ".parity_err"}, s_perr, perr);
    check_output({tag, ".addr_err"}, s_aerr, aerr);
    check_output({tag, ".trunc_err"}, s_terr, 0);
    check_output({tag, ".byte_count"}, got_q.size(), len);
    bad_bytes = 0;
    for (int i = 0; i < len; i++) begin
      e = exp_bytes.pop_front();
      if (i >= got_q.size() || got_q[i] != e) bad_bytes++;
    end
    check_output({tag, ".payload_diffs"}, bad_bytes, 0);
    check_output({tag, ".reads"}, rd_cnt, len + 2);
    if (!perr && !aerr) exp_pkt[sel]++;
    else                exp_err[sel]++;
    check_output({tag, ".pkt_count"}, s_pcnt, exp_pkt[sel]);
    check_output({tag, ".err_count"}, s_ecnt, exp_err[sel]);
    got_q.delete();
    rd_cnt = 0;
  endtask

  task automatic set_hold(input int mode, input int len);
    hold_mode = mode;
    hold_left = 0;
    next_hold_at = 4;
    hold_limit = len;
  endtask

  initial begin
    bit pre;
    int n, start, len;
    logic [1:0] addr;
    bit bad;

    errors = 0; checks = 0; rd_cnt = 0; done_cnt = 0; cyc = 0;
    last_bv_cyc = 0; done_cyc = 0; rd_pending = 1'b0;
    sel = 1'b0; src_vld = 1'b0; hold = 1'b0;
    pipe[0] = 8'd0; pipe[1] = 8'd0; pipe[2] = 8'd0;
    exp_pkt[0] = 0; exp_pkt[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
    set_hold(0, 0);

    vecs[0] = '{1'b0, 13, 2'd1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 17, 2'd2, 1'b1, 0, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b0,  0, 2'd1, 1'b0, 0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0,  3, 2'd1, 1'b0, 0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 16, 2'd1, 1'b0, 1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1,  5, 2'd3, 1'b0, 0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 63, 2'd1, 1'b1, 2, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0,  1, 2'd0, 1'b0, 0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    step();
    step();
    check_output("reset.flags_lat1", {bus0.read_enb, bus0.byte_valid, bus0.pkt_done,
                 bus0.parity_err, bus0.addr_err, bus0.trunc_err}, 0);
    check_output("reset.flags_lat3", {bus1.read_enb, bus1.byte_valid, bus1.pkt_done,
                 bus1.parity_err, bus1.addr_err, bus1.trunc_err}, 0);
    check_output("reset.counts_lat1", {bus0.pkt_count, bus0.err_count, bus0.pkt_len}, 0);
    reset = 1'b0;
    step();

    // Directed table.
    pre = 1'b0;
    for (int i = 0; i < NVEC; i++) begin
      sel = vecs[i].sel;
      set_hold(vecs[i].hold_mode, vecs[i].len);
      if (!pre) apply_stimulus(vecs[i].len, vecs[i].addr, vecs[i].bad, vecs[i].len);
      pre = 1'b0;
      if (vecs[i].b2b && i + 1 < NVEC) begin
        apply_stimulus(vecs[i + 1].len, vecs[i + 1].addr, vecs[i + 1].bad, vecs[i + 1].len);
        pre = 1'b1;
      end
      expect_packet($sformatf("vec%0d", i), vecs[i].len, vecs[i].exp_perr, vecs[i].exp_aerr);
    end
    check_output("table.fifo_drained", src_q.size(), 0);

    // Random packets with random backpressure.
    for (int r = 0; r < 16; r++) begin
      sel  = 1'($urandom_range(0, 1));
      len  = $urandom_range(0, 63);
      addr = 2'($urandom_range(0, 3));
      bad  = (len > 0) && ($urandom_range(0, 3) == 0);
      set_hold(2, len);
      apply_stimulus(len, addr, bad, len);
      expect_packet($sformatf("rand%0d", r), len, bad, addr != 2'd1);
    end
    set_hold(0, 0);
    step();

    // Truncated packet on the latency-1 receiver: 5 of 20 bytes, then silence.
    sel = 1'b0;
    apply_stimulus(20, 2'd1, 1'b0, 5);
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < 500) begin
      step();
      n++;
    end
    exp_err[0]++;
    check_output("trunc.pkt_done", done_cnt - start, 1);
    check_output("trunc.trunc_err", s_terr, 1);
    check_output("trunc.latency", done_cyc - last_bv_cyc, TIMEOUT);
    check_output("trunc.byte_count", got_q.size(), 5);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (i >= got_q.size() || got_q[i] != exp_bytes[i]) n++;
    end
    check_output("trunc.payload_diffs", n, 0);
    check_output("trunc.err_count", s_ecnt, exp_err[0]);
    check_output("trunc.pkt_count", s_pcnt, exp_pkt[0]);
    exp_bytes.delete();
    got_q.delete();
    rd_cnt = 0;
    apply_stimulus(7, 2'd1, 1'b0, 7);
    expect_packet("after_trunc", 7, 1'b0, 1'b0);

    // Reset in the middle of a payload.
    apply_stimulus(30, 2'd1, 1'b0, 30);
    n = 0;
    while (got_q.size() < 3 && n < 200) begin
      step();
      n++;
    end
    check_output("midreset.reached_body", got_q.size() >= 3, 1);
    start = done_cnt;
    src_q.delete();
    reset = 1'b1;
    step();
    check_output("midreset.flags", {m_rd, m_bv, m_pd, m_perr, m_aerr, m_terr}, 0);
    check_output("midreset.values", {m_pcnt, m_ecnt, m_len, m_byte}, 0);
    check_output("midreset.no_pkt_done", done_cnt - start, 0);
    reset = 1'b0;
    exp_pkt[0] = 0; exp_pkt[1] = 0; exp_err[0] = 0; exp_err[1] = 0;
    exp_bytes.delete();
    got_q.delete();
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) step();
    check_output("midreset.idle_reads", rd_cnt, 0);
    check_output("midreset.idle_done", done_cnt - start, 0);
    apply_stimulus(9, 2'd1, 1'b0, 9);
    expect_packet("after_reset", 9, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
